// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe
//   Two-stage pipelined bitwise logic unit. It applies a 3-bit opcode to two
//   WIDTH-bit operands and returns the result together with zero and parity flags.
//   Both sides use a valid/ready handshake. Throughput is one beat per cycle,
//   and this holds under backpressure as well.
//
//   Build option: define LOGIC_POPCOUNT_EN to make op 111 return popcount(a).
//   When it is not defined, op 111 returns zero.
//
// Ports
//   clk, rst_n           clock, synchronous active-low reset
//   in_valid/in_ready    operand handshake (a, b, sel sampled on transfer)
//   out_valid/out_ready  result handshake (result, zero, parity)
//   busy                 at least one stage holds a beat
module logic_unit_pipe #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             parity,
    output logic             busy
);

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [2:0]       sel;
    } s1_t;

    logic             s1_v, s2_v;
    logic             s1_adv, s2_adv;
    s1_t              s1;
    logic [WIDTH-1:0] op_res;

    // A stage may take a new beat if it is empty or if its current beat
    // leaves in this same cycle. This lets a drain and a refill happen
    // together without inserting a bubble.
    assign s2_adv    = !s2_v || out_ready;
    assign s1_adv    = !s1_v || s2_adv;
    assign in_ready  = s1_adv;
    assign out_valid = s2_v;
    assign busy      = s1_v || s2_v;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_v <= 1'b0;
            s1   <= '0;
        end else if (s1_adv) begin
            s1_v <= in_valid;
            if (in_valid) s1 <= '{a: a, b: b, sel: sel};
        end
    end

`ifdef LOGIC_POPCOUNT_EN
    logic [WIDTH-1:0] pop;
    always_comb begin
        pop = '0;
        for (int i = 0; i < WIDTH; i++) pop = pop + WIDTH'(s1.a[i]);
    end
`endif

    always_comb begin
        op_res = '0;
        case (s1.sel)
            3'b000: op_res = s1.a & s1.b;
            3'b001: op_res = s1.a | s1.b;
            3'b010: op_res = s1.a ^ s1.b;
            3'b011: op_res = ~(s1.a ^ s1.b);
            3'b100: op_res = ~s1.a;
            3'b101: op_res = ~(s1.a & s1.b);
            3'b110: op_res = ~(s1.a | s1.b);
            default: begin
`ifdef LOGIC_POPCOUNT_EN
                op_res = pop;
`else
                op_res = '0;
`endif
            end
        endcase
    end

    // Payload registers load only when a real beat moves in. As a result,
    // the outputs stay frozen while out_valid is held and out_ready is low.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_v   <= 1'b0;
            result <= '0;
            zero   <= 1'b1;
            parity <= 1'b0;
        end else if (s2_adv) begin
            s2_v <= s1_v;
            if (s1_v) begin
                result <= op_res;
                zero   <= ~|op_res;
                parity <= ^op_res;
            end
        end
    end

endmodule
